// File: rtl/snes_pad_responder_if.sv
// Pin bundle between the console/frontend side and the SNES pad responder.
// master drives the console pins and button words; slave is the responder.
interface snes_pad_responder_if;
  logic        JOY_STRB;
  logic        JOY1_CLK;
  logic        JOY2_CLK;
  logic        JOY2_P6;
  logic        MULTITAP_EN;
  logic [11:0] PAD1;
  logic [11:0] PAD2;
  logic [11:0] PAD3;
  logic [11:0] PAD4;
  logic [11:0] PAD5;
  logic [1:0]  JOY1_DI;
  logic [1:0]  JOY2_DI;
  logic        JOY2_P6_in;

  modport master (
    output JOY_STRB, JOY1_CLK, JOY2_CLK, JOY2_P6, MULTITAP_EN,
    output PAD1, PAD2, PAD3, PAD4, PAD5,
    input  JOY1_DI, JOY2_DI, JOY2_P6_in
  );

  modport slave (
    input  JOY_STRB, JOY1_CLK, JOY2_CLK, JOY2_P6, MULTITAP_EN,
    input  PAD1, PAD2, PAD3, PAD4, PAD5,
    output JOY1_DI, JOY2_DI, JOY2_P6_in
  );
endinterface

// File: rtl/snes_pad_responder.sv
// SNES joypad responder: standard pad on port 1, standard pad or 4-player
// multitap on port 2, driven from the console's strobe/clock/IOBit pins.
module snes_pad_responder #(
  parameter int unsigned MULTITAP_SUPPORT = 1
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  snes_pad_responder_if.slave  bus
);

  logic              s_strb, s_clk1, p_clk1, s_clk2, p_clk2, s_p6, s_mten;
  logic              rise1, rise2, mt_on;
  logic [4:0][11:0]  pad;
  logic [4:0][15:0]  sr_q, sr_d;
  logic [1:0]        joy1_di_q, joy1_di_d, joy2_di_q, joy2_di_d;

  function automatic logic [15:0] shr(input logic [15:0] v);
    return {1'b0, v[15:1]};
  endfunction

  assign pad   = {bus.PAD5, bus.PAD4, bus.PAD3, bus.PAD2, bus.PAD1};
  assign rise1 = s_clk1 & ~p_clk1;
  assign rise2 = s_clk2 & ~p_clk2;
  assign mt_on = (MULTITAP_SUPPORT != 0) && s_mten;

  always_comb begin
    sr_d = sr_q;
    if (s_strb) begin
      // Live reload; any clock edge seen during strobe is dropped.
      for (int i = 0; i < 5; i++) begin
        sr_d[i] = {4'hF, ~pad[i]};
      end
    end else begin
      if (rise1) sr_d[0] = shr(sr_q[0]);
      if (rise2) begin
        if (!mt_on) begin
          sr_d[1] = shr(sr_q[1]);
        end else if (s_p6) begin
          sr_d[1] = shr(sr_q[1]);
          sr_d[2] = shr(sr_q[2]);
        end else begin
          sr_d[3] = shr(sr_q[3]);
          sr_d[4] = shr(sr_q[4]);
        end
      end
    end
    // Pads 3-5 collapse to constants when the multitap is not built in.
    if (MULTITAP_SUPPORT == 0) begin
      sr_d[2] = '1;
      sr_d[3] = '1;
      sr_d[4] = '1;
    end

    joy1_di_d = {1'b1, sr_d[0][0]};
    if (!mt_on) begin
      joy2_di_d = {1'b1, sr_d[1][0]};
    end else if (s_strb) begin
      joy2_di_d = {1'b0, sr_d[1][0]};
    end else if (s_p6) begin
      joy2_di_d = {sr_d[2][0], sr_d[1][0]};
    end else begin
      joy2_di_d = {sr_d[4][0], sr_d[3][0]};
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      s_strb    <= 1'b0;
      s_clk1    <= 1'b1;
      p_clk1    <= 1'b1;
      s_clk2    <= 1'b1;
      p_clk2    <= 1'b1;
      s_p6      <= 1'b1;
      s_mten    <= 1'b0;
      sr_q      <= '1;
      joy1_di_q <= 2'b11;
      joy2_di_q <= 2'b11;
    end else begin
      s_strb    <= bus.JOY_STRB;
      s_clk1    <= bus.JOY1_CLK;
      p_clk1    <= s_clk1;
      s_clk2    <= bus.JOY2_CLK;
      p_clk2    <= s_clk2;
      s_p6      <= bus.JOY2_P6;
      s_mten    <= bus.MULTITAP_EN;
      sr_q      <= sr_d;
      joy1_di_q <= joy1_di_d;
      joy2_di_q <= joy2_di_d;
    end
  end

  assign bus.JOY1_DI    = joy1_di_q;
  assign bus.JOY2_DI    = joy2_di_q;
  assign bus.JOY2_P6_in = s_p6;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: reset, strobe/shift, multitap pairs,
// multitap disable and mid-read reset, with hand-computed pin levels.
module tb_snes_pad_responder;

  logic mclk;
  logic rst;
  int   n_cmp;
  int   n_err;

  snes_pad_responder_if bus ();

  snes_pad_responder #(.MULTITAP_SUPPORT(1)) dut (
    .MCLK  (mclk),
    .RESET (rst),
    .bus   (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pulse1();
    bus.JOY1_CLK = 1'b0;
    step(2);
    bus.JOY1_CLK = 1'b1;
    step(2);
  endtask

  task automatic pulse2();
    bus.JOY2_CLK = 1'b0;
    step(2);
    bus.JOY2_CLK = 1'b1;
    step(2);
  endtask

  task automatic strobe();
    bus.JOY_STRB = 1'b1;
    step(4);
    bus.JOY_STRB = 1'b0;
    step(2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.JOY_STRB    = 1'b0;
    bus.JOY1_CLK    = 1'b1;
    bus.JOY2_CLK    = 1'b1;
    bus.JOY2_P6     = 1'b1;
    bus.MULTITAP_EN = 1'b0;
    bus.PAD1 = '0;
    bus.PAD2 = '0;
    bus.PAD3 = '0;
    bus.PAD4 = '0;
    bus.PAD5 = '0;
    step(2);
    chk("rst_joy1", bus.JOY1_DI, 2'b11);
    chk("rst_joy2", bus.JOY2_DI, 2'b11);
    chk("rst_p6in", {1'b0, bus.JOY2_P6_in}, 2'b01);
    rst = 1'b0;
    step(2);

    // 1: B pressed on pad 1, two-cycle latency, then Y released
    bus.PAD1 = 12'h001;
    bus.JOY_STRB = 1'b1;
    step(1);
    chk("t1_lat1", bus.JOY1_DI, 2'b11);
    step(1);
    chk("t1_lat2", bus.JOY1_DI, 2'b10);
    step(2);
    bus.JOY_STRB = 1'b0;
    step(2);
    chk("t1_hold", bus.JOY1_DI, 2'b10);
    pulse1();
    chk("t1_bit1", bus.JOY1_DI, 2'b11);

    // 2: all buttons pressed, 16 bits then zero fill
    bus.PAD1 = 12'hFFF;
    strobe();
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t2_bit%0d", i), bus.JOY1_DI,
          (i >= 12 && i <= 15) ? 2'b11 : 2'b10);
      pulse1();
    end
    pulse1();
    pulse1();
    pulse1();
    chk("t2_shift20", bus.JOY1_DI, 2'b10);

    // 3: strobe held, clock toggled, pad follows live
    bus.PAD1 = 12'h001;
    bus.JOY_STRB = 1'b1;
    step(2);
    chk("t3_live_b", bus.JOY1_DI, 2'b10);
    bus.JOY1_CLK = 1'b0;
    step(2);
    chk("t3_clk_lo", bus.JOY1_DI, 2'b10);
    bus.JOY1_CLK = 1'b1;
    step(2);
    chk("t3_clk_hi", bus.JOY1_DI, 2'b10);
    bus.PAD1 = 12'h000;
    step(2);
    chk("t3_live_rel", bus.JOY1_DI, 2'b11);
    bus.PAD1 = 12'h001;
    step(2);
    chk("t3_live_prs", bus.JOY1_DI, 2'b10);
    bus.JOY_STRB = 1'b0;
    step(2);
    chk("t3_after", bus.JOY1_DI, 2'b10);
    pulse1();
    chk("t3_bit1", bus.JOY1_DI, 2'b11);

    // 4: multitap, pad2 A and pad4 B
    bus.MULTITAP_EN = 1'b1;
    bus.PAD2 = 12'h100;
    bus.PAD3 = 12'h000;
    bus.PAD4 = 12'h001;
    bus.PAD5 = 12'h000;
    bus.JOY2_P6 = 1'b1;
    bus.JOY_STRB = 1'b1;
    step(2);
    chk("t4_sig", bus.JOY2_DI, 2'b01);
    bus.JOY_STRB = 1'b0;
    step(2);
    chk("t4_p6hi_b0", bus.JOY2_DI, 2'b11);
    for (int i = 0; i < 8; i++) pulse2();
    chk("t4_p6hi_a", bus.JOY2_DI, 2'b10);
    bus.JOY2_P6 = 1'b0;
    step(2);
    chk("t4_p6in", {1'b0, bus.JOY2_P6_in}, 2'b00);
    chk("t4_p6lo_b", bus.JOY2_DI, 2'b10);
    pulse2();
    chk("t4_p6lo_b1", bus.JOY2_DI, 2'b11);
    bus.JOY2_P6 = 1'b1;
    step(2);
    chk("t4_back_a", bus.JOY2_DI, 2'b10);
    pulse2();
    chk("t4_back_x", bus.JOY2_DI, 2'b11);

    // 5: multitap disabled, pads 3-5 ignored
    bus.MULTITAP_EN = 1'b0;
    bus.JOY2_P6 = 1'b0;
    bus.PAD2 = 12'h000;
    bus.PAD3 = 12'hFFF;
    bus.PAD4 = 12'hFFF;
    bus.PAD5 = 12'hFFF;
    bus.JOY_STRB = 1'b1;
    step(2);
    chk("t5_strb", bus.JOY2_DI, 2'b11);
    bus.JOY_STRB = 1'b0;
    step(2);
    chk("t5_p6lo", bus.JOY2_DI, 2'b11);
    pulse2();
    pulse2();
    pulse2();
    chk("t5_shift3", bus.JOY2_DI, 2'b11);

    // 6: reset after 5 shifts, then read without strobe
    bus.JOY2_P6 = 1'b1;
    bus.PAD1 = 12'hFFF;
    strobe();
    for (int i = 0; i < 5; i++) pulse1();
    chk("t6_pre", bus.JOY1_DI, 2'b10);
    rst = 1'b1;
    step(1);
    chk("t6_rst_joy1", bus.JOY1_DI, 2'b11);
    chk("t6_rst_joy2", bus.JOY2_DI, 2'b11);
    rst = 1'b0;
    step(1);
    chk("t6_bit0", bus.JOY1_DI, 2'b11);
    for (int i = 1; i <= 16; i++) begin
      pulse1();
      chk($sformatf("t6_bit%0d", i), bus.JOY1_DI, (i < 16) ? 2'b11 : 2'b10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
